// File: rtl/adder_tree_pkt_accum.sv
// Packet accumulator behind the pipelined adder tree: sums per-beat tree outputs over an
// sop..eop packet and presents one total, beat count and sop ctl per packet.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no open packet; next beat must carry sop
// ACCUM | packet open; acc/cnt/ctl hold the running sums
module adder_tree_pkt_accum #(
    parameter int BIT_LEN  = 16,
    parameter int ACC_BITS = 32,
    parameter int CNT_BITS = 16,
    parameter int CTL_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [BIT_LEN-1:0]  i_dat,
    input  logic [CTL_BITS-1:0] i_ctl,
    input  logic                i_val,
    input  logic                i_sop,
    input  logic                i_eop,
    output logic                o_rdy,
    output logic [ACC_BITS-1:0] o_dat,
    output logic [CNT_BITS-1:0] o_cnt,
    output logic [CTL_BITS-1:0] o_ctl,
    output logic                o_val,
    input  logic                i_rdy,
    output logic                o_drop
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state, state_nxt;
    logic [ACC_BITS-1:0] acc, acc_nxt;
    logic [CNT_BITS-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CTL_BITS-1:0] ctl_q, ctl_nxt;
    logic [ACC_BITS-1:0] dat_nxt, dat_ext;
    logic [CNT_BITS-1:0] ocnt_nxt;
    logic [CTL_BITS-1:0] octl_nxt;
    logic                val_nxt, drop_nxt, beat;

    // Single result register: a new result may load in the same cycle the old one drains.
    assign o_rdy   = !o_val || i_rdy;
    assign beat    = i_val && o_rdy;
    assign dat_ext = ACC_BITS'(i_dat);
    assign cnt_inc = (cnt == {CNT_BITS{1'b1}}) ? cnt : cnt + CNT_BITS'(1);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ctl_nxt   = ctl_q;
        dat_nxt   = o_dat;
        ocnt_nxt  = o_cnt;
        octl_nxt  = o_ctl;
        val_nxt   = o_val && !i_rdy;
        drop_nxt  = 1'b0;
        if (beat) begin
            if (i_sop) begin
                // A sop inside an open packet discards the partial sum and restarts.
                drop_nxt = (state == ACCUM);
                if (i_eop) begin
                    dat_nxt   = dat_ext;
                    ocnt_nxt  = CNT_BITS'(1);
                    octl_nxt  = i_ctl;
                    val_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    acc_nxt   = dat_ext;
                    cnt_nxt   = CNT_BITS'(1);
                    ctl_nxt   = i_ctl;
                    state_nxt = ACCUM;
                end
            end else if (state == IDLE) begin
                drop_nxt = 1'b1;
            end else if (i_eop) begin
                dat_nxt   = acc + dat_ext;
                ocnt_nxt  = cnt_inc;
                octl_nxt  = ctl_q;
                val_nxt   = 1'b1;
                state_nxt = IDLE;
            end else begin
                acc_nxt = acc + dat_ext;
                cnt_nxt = cnt_inc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            ctl_q  <= '0;
            o_dat  <= '0;
            o_cnt  <= '0;
            o_ctl  <= '0;
            o_val  <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            ctl_q  <= ctl_nxt;
            o_dat  <= dat_nxt;
            o_cnt  <= ocnt_nxt;
            o_ctl  <= octl_nxt;
            o_val  <= val_nxt;
            o_drop <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_adder_tree_pkt_accum.sv
// Directed bench for adder_tree_pkt_accum: scoreboard of expected packet results checked
// when each result transfers, plus a 16-bit accumulator instance for the wrap case.
module tb_adder_tree_pkt_accum;

    typedef struct packed {
        logic [31:0] dat;
        logic [15:0] cnt;
        logic [7:0]  ctl;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_dat = '0;
    logic [7:0]  i_ctl = '0;
    logic        i_val = 1'b0, i_sop = 1'b0, i_eop = 1'b0, i_rdy = 1'b1;
    logic        o_rdy, o_val, o_drop;
    logic [31:0] o_dat;
    logic [15:0] o_cnt;
    logic [7:0]  o_ctl;
    logic        w_rdy, w_val, w_drop;
    logic [15:0] w_dat, w_cnt;
    logic [7:0]  w_ctl;

    res_t q[$];
    int   n_vec = 0, n_err = 0, drop_seen = 0, stalls = 0;

    always #5 clk = ~clk;

    adder_tree_pkt_accum dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dat(i_dat), .i_ctl(i_ctl), .i_val(i_val),
        .i_sop(i_sop), .i_eop(i_eop), .o_rdy(o_rdy), .o_dat(o_dat), .o_cnt(o_cnt),
        .o_ctl(o_ctl), .o_val(o_val), .i_rdy(i_rdy), .o_drop(o_drop)
    );

    adder_tree_pkt_accum #(.ACC_BITS(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dat(i_dat), .i_ctl(i_ctl), .i_val(i_val),
        .i_sop(i_sop), .i_eop(i_eop), .o_rdy(w_rdy), .o_dat(w_dat), .o_cnt(w_cnt),
        .o_ctl(w_ctl), .o_val(w_val), .i_rdy(i_rdy), .o_drop(w_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result transfers on the posedge after a negedge that sees o_val & i_rdy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_drop) drop_seen++;
            if (o_val && i_rdy) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_val", {31'b0, o_val}, 32'd0);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    check("sb_dat", o_dat, e.dat);
                    check("sb_cnt", {16'b0, o_cnt}, {16'b0, e.cnt});
                    check("sb_ctl", {24'b0, o_ctl}, {24'b0, e.ctl});
                end
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [15:0] c, input logic [7:0] t);
        res_t r;
        r.dat = d; r.cnt = c; r.ctl = t;
        q.push_back(r);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [15:0] d, input logic s, input logic e, input logic [7:0] c);
        bit ok;
        ok = 0;
        i_val = 1'b1; i_dat = d; i_sop = s; i_eop = e; i_ctl = c;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_rdy) begin ok = 1; break; end
            stalls++;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_dat = '0; i_ctl = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_val", {31'b0, o_val}, 32'd0);
        check("rst_rdy", {31'b0, o_rdy}, 32'd1);
        check("rst_dat", o_dat, 32'd0);
        check("rst_cnt", {16'b0, o_cnt}, 32'd0);
        check("rst_ctl", {24'b0, o_ctl}, 32'd0);
        check("rst_drop", {31'b0, o_drop}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        idle(1);

        // 4-beat packet
        push(32'd10, 16'd4, 8'h5A);
        send(16'd1, 1, 0, 8'h5A);
        send(16'd2, 0, 0, 8'h00);
        send(16'd3, 0, 0, 8'h00);
        send(16'd4, 0, 1, 8'h00);
        @(negedge clk);
        check("lat_val", {31'b0, o_val}, 32'd1);
        idle(2);

        // back-to-back single-beat packets
        stalls = 0;
        repeat (3) push(32'h0000FFFF, 16'd1, 8'd3);
        repeat (3) send(16'hFFFF, 1, 1, 8'd3);
        check("b2b_no_stall", stalls, 32'd0);
        idle(3);
        check("b2b_sb_empty", q.size(), 32'd0);

        // backpressure: pending result with next packet arriving
        i_rdy = 1'b0;
        push(32'd5, 16'd1, 8'd1);
        push(32'd15, 16'd2, 8'd2);
        send(16'd5, 1, 1, 8'd1);
        fork
            begin
                send(16'd7, 1, 0, 8'd2);
                send(16'd8, 0, 1, 8'd0);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_rdy_low", {31'b0, o_rdy}, 32'd0);
                    check("bp_dat_held", o_dat, 32'd5);
                end
                @(posedge clk); #1;
                i_rdy = 1'b1;
            end
        join
        idle(3);
        check("bp_sb_empty", q.size(), 32'd0);

        // 16-bit accumulator wraps; 32-bit instance carries into bit 16
        push(32'h00010001, 16'd2, 8'd9);
        send(16'hFFFF, 1, 0, 8'd9);
        send(16'h0002, 0, 1, 8'd0);
        @(negedge clk);
        check("wrap_val", {31'b0, w_val}, 32'd1);
        check("wrap_dat", {16'b0, w_dat}, 32'h0001);
        check("wrap_cnt", {16'b0, w_cnt}, 32'd2);
        idle(2);

        // malformed framing
        drop_seen = 0;
        send(16'd3, 0, 0, 8'd0);
        idle(3);
        check("drop_idle", drop_seen, 32'd1);
        check("drop_no_val", {31'b0, o_val}, 32'd0);
        push(32'd15, 16'd2, 8'd4);
        send(16'd1, 1, 0, 8'd1);
        send(16'd2, 0, 0, 8'd0);
        send(16'd7, 1, 0, 8'd4);
        send(16'd8, 0, 1, 8'd0);
        idle(3);
        check("drop_midpkt", drop_seen, 32'd2);
        check("drop_sb_empty", q.size(), 32'd0);

        // async reset mid-packet
        send(16'd100, 1, 0, 8'd0);
        send(16'd200, 0, 0, 8'd0);
        rst_n = 1'b0; #1;
        check("rstpkt_val", {31'b0, o_val}, 32'd0);
        check("rstpkt_rdy", {31'b0, o_rdy}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        idle(1);

        // async reset with a result pending
        i_rdy = 1'b0;
        send(16'd9, 1, 1, 8'd0);
        @(negedge clk);
        check("rstval_pre", {31'b0, o_val}, 32'd1);
        check("rstval_rdy_pre", {31'b0, o_rdy}, 32'd0);
        #2; rst_n = 1'b0; #1;
        check("rstval_val", {31'b0, o_val}, 32'd0);
        check("rstval_rdy", {31'b0, o_rdy}, 32'd1);
        check("rstval_dat", o_dat, 32'd0);
        i_rdy = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        idle(1);

        drop_seen = 0;
        push(32'd6, 16'd3, 8'h0C);
        send(16'd1, 0 + 1, 0, 8'h0C);
        send(16'd2, 0, 0, 8'd0);
        send(16'd3, 0, 1, 8'd0);
        idle(3);
        check("post_rst_sb_empty", q.size(), 32'd0);
        check("post_rst_no_drop", drop_seen, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
